pwm_actuator_driver: RTL and testbench

- Downstream of pid_controller. Consumes its signed Q4.4 `ctrl_out` and drives one H-bridge actuator channel.
- Outputs are a PWM signal and a direction bit.
- Applies a per-period slew-rate limit, a deadband and a soft-stop ramp.
- Duty and direction change only at PWM period boundaries, so there are no glitches.

---
 rtl/pwm_actuator_driver.sv | 195 +++++++++++++++++++
 tb/tb_pwm_actuator_driver.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_actuator_driver.sv
// pwm_actuator_driver
// Turns the signed Q4.4 command from pid_controller into a PWM signal and a
// direction bit for one H-bridge channel. The value in effect moves toward the
// command by at most SLEW_MAX LSBs per PWM period. Small values are forced off
// by a deadband. Dropping en ramps the output down to zero before the block
// goes idle. Duty and direction only change at period boundaries.
//
// Optional feature (macro PWM_CENTER_ALIGNED_EN):
//   Defined   : up/down counter with a period of 2*PERIOD cycles. The boundary
//               is at counter==0 while counting down, and pwm_out = counter < mag.
//   Undefined : edge-aligned up-counter 0..PERIOD, and pwm_out = counter < 2*mag.
//
// Ports:
//   clk          in   clock
//   rst          in   synchronous, active-low reset
//   en           in   run enable; a falling edge starts the soft-stop ramp
//   ctrl_in      in   [7:0] signed Q4.4 command
//   ctrl_valid   in   ctrl_in is sampled while high (RUN only)
//   pwm_out      out  registered PWM output
//   dir_out      out  1 = negative command
//   applied      out  [7:0] signed Q4.4 value currently in effect
//   period_start out  one-cycle pulse on the boundary cycle
//   sat_flag     out  sticky; set when a -128 command was clamped to -127
//   busy         out  high in RUN or STOP
module pwm_actuator_driver #(
  parameter int CNT_W    = 8,
  parameter int PERIOD   = 255,
  parameter int SLEW_MAX = 8,
  parameter int DEADBAND = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] ctrl_in,
  input  logic       ctrl_valid,
  output logic       pwm_out,
  output logic       dir_out,
  output logic [7:0] applied,
  output logic       period_start,
  output logic       sat_flag,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  localparam logic [CNT_W-1:0]  CNT_TOP = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic signed [8:0] SLEW_P  = 9'(SLEW_MAX);
  localparam logic signed [8:0] SLEW_N  = 9'(-SLEW_MAX);
  localparam logic [7:0]        DB      = 8'(DEADBAND);
  localparam int                DW      = (CNT_W > 8) ? CNT_W : 8;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  counter;
  logic [7:0]        target;
  logic [7:0]        duty;
  logic              boundary;

  logic signed [8:0] delta;
  logic signed [8:0] step;
  logic [7:0]        applied_next;
  logic [7:0]        mag_next;
  logic [7:0]        duty_next;
  logic              dir_next;

`ifdef PWM_CENTER_ALIGNED_EN
  logic cnt_down;
  assign boundary = (state != IDLE) && cnt_down && (counter == '0);
`else
  assign boundary = (state != IDLE) && (counter == CNT_TOP);
`endif

  assign period_start = boundary;
  assign busy         = (state != IDLE);

  // Slew-limited next value, plus the duty/direction derived from it.
  // Both operands stay in [-127, 127], so the 9-bit delta cannot overflow.
  always_comb begin
    delta        = {target[7], target} - {applied[7], applied};
    step         = delta;
    applied_next = '0;
    mag_next     = '0;
    duty_next    = '0;
    dir_next     = dir_out;
    if (delta > SLEW_P) begin
      step = SLEW_P;
    end else if (delta < SLEW_N) begin
      step = SLEW_N;
    end
    applied_next = 8'($signed({applied[7], applied}) + step);
    mag_next     = applied_next[7] ? (8'd0 - applied_next) : applied_next;
    // Inside the deadband the output goes off, but the direction is held.
    // This keeps the H-bridge from toggling around zero.
    if (mag_next > DB) begin
`ifdef PWM_CENTER_ALIGNED_EN
      duty_next = mag_next;
`else
      duty_next = 8'({mag_next, 1'b0});
`endif
      dir_next  = applied_next[7];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (en) state_next = RUN;
      RUN:  if (!en) state_next = STOP;
      STOP: begin
        if (en) begin
          state_next = RUN;
        end else if (boundary && (applied_next == '0)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The counter is held at 0 while idle and on the cycle that leaves IDLE.
  // That way the first RUN cycle starts at 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      counter <= '0;
`ifdef PWM_CENTER_ALIGNED_EN
      cnt_down <= 1'b0;
`endif
    end else if ((state == IDLE) || (state_next == IDLE)) begin
      counter <= '0;
`ifdef PWM_CENTER_ALIGNED_EN
      cnt_down <= 1'b0;
`endif
    end else begin
`ifdef PWM_CENTER_ALIGNED_EN
      if (!cnt_down) begin
        if (counter == CNT_TOP) begin
          cnt_down <= 1'b1;
          counter  <= counter - CNT_ONE;
        end else begin
          counter  <= counter + CNT_ONE;
        end
      end else begin
        if (counter == '0) begin
          cnt_down <= 1'b0;
          counter  <= CNT_ONE;
        end else begin
          counter  <= counter - CNT_ONE;
        end
      end
`else
      counter <= (counter == CNT_TOP) ? '0 : counter + CNT_ONE;
`endif
    end
  end

  // The target is forced to zero on the RUN->STOP transition, so the
  // slew logic ramps the output down on its own.
  always_ff @(posedge clk) begin
    if (!rst) begin
      target   <= '0;
      sat_flag <= 1'b0;
      applied  <= '0;
      duty     <= '0;
      dir_out  <= 1'b0;
      pwm_out  <= 1'b0;
    end else begin
      if ((state == RUN) && !en) begin
        target <= '0;
      end else if ((state == RUN) && ctrl_valid) begin
        if (ctrl_in == 8'h80) begin
          target   <= 8'h81;
          sat_flag <= 1'b1;
        end else begin
          target   <= ctrl_in;
        end
      end
      if (boundary) begin
        applied <= applied_next;
        duty    <= duty_next;
        dir_out <= dir_next;
      end
      pwm_out <= (state != IDLE) && (DW'(counter) < DW'(duty));
    end
  end

endmodule

// File: tb/tb_pwm_actuator_driver.sv
// tb_pwm_actuator_driver
// Self-checking bench for pwm_actuator_driver in its default edge-aligned build.
// Expected applied/direction values are queued when a command is driven.
// They are popped and compared at each period boundary.
//
// Ports: none (top-level bench).
module tb_pwm_actuator_driver;

  localparam int PERIOD = 255;

  typedef struct {
    logic [7:0] applied;
    logic       dir;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] ctrl_in;
  logic       ctrl_valid;
  logic       pwm_out;
  logic       dir_out;
  logic [7:0] applied;
  logic       period_start;
  logic       sat_flag;
  logic       busy;

  int   num_checks = 0;
  int   num_errors = 0;
  exp_t sb[$];

  pwm_actuator_driver dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .ctrl_in      (ctrl_in),
    .ctrl_valid   (ctrl_valid),
    .pwm_out      (pwm_out),
    .dir_out      (dir_out),
    .applied      (applied),
    .period_start (period_start),
    .sat_flag     (sat_flag),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Sets en, lets the FSM react, then optionally pulses ctrl_valid for one cycle.
  task automatic applyStimulus(input logic en_v, input logic pulse, input logic [7:0] cmd);
    @(negedge clk);
    en = en_v;
    @(posedge clk);
    if (pulse) begin
      @(negedge clk);
      ctrl_in    = cmd;
      ctrl_valid = 1'b1;
      @(negedge clk);
      ctrl_valid = 1'b0;
    end
  endtask

  // Staircase toward 'to' in steps of at most 8. Direction follows the sign
  // only outside the +/-2 deadband.
  task automatic pushRamp(input int from, input int to, input logic dir_in);
    int   cur;
    int   stp;
    logic d;
    cur = from;
    d   = dir_in;
    while (cur != to) begin
      stp = to - cur;
      if (stp > 8) stp = 8;
      if (stp < -8) stp = -8;
      cur += stp;
      if (cur > 2 || cur < -2) d = (cur < 0);
      sb.push_back('{applied: 8'(cur), dir: d});
    end
  endtask

  // Returns just after the posedge that ends the boundary cycle.
  task automatic waitBoundary();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * (PERIOD + 1) + 8; i++) begin
      @(negedge clk);
      if (period_start) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput("boundary_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drainScoreboard();
    exp_t e;
    while (sb.size() > 0) begin
      waitBoundary();
      e = sb.pop_front();
      checkOutput("applied", 32'(applied), 32'(e.applied));
      checkOutput("dir_out", 32'(dir_out), 32'(e.dir));
    end
  endtask

  task automatic countPwm(output int n);
    n = 0;
    repeat (PERIOD + 1) begin
      @(negedge clk);
      if (pwm_out) n++;
    end
  endtask

  initial begin
    int n;
    rst        = 1'b0;
    en         = 1'b0;
    ctrl_in    = '0;
    ctrl_valid = 1'b0;

    // Reset and hold
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_pwm", 32'(pwm_out), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_applied", 32'(applied), 32'd0);
    checkOutput("rst_dir", 32'(dir_out), 32'd0);
    checkOutput("rst_sat", 32'(sat_flag), 32'd0);
    checkOutput("rst_pstart", 32'(period_start), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    repeat (300) begin
      @(negedge clk);
      if (period_start || pwm_out || busy) n++;
    end
    checkOutput("idle_hold", 32'(n), 32'd0);

    // Slew ramp to +2.0
    applyStimulus(1'b1, 1'b1, 8'd32);
    sb.push_back('{applied: 8'd8,  dir: 1'b0});
    sb.push_back('{applied: 8'd16, dir: 1'b0});
    sb.push_back('{applied: 8'd24, dir: 1'b0});
    sb.push_back('{applied: 8'd32, dir: 1'b0});
    sb.push_back('{applied: 8'd32, dir: 1'b0});
    drainScoreboard();
    countPwm(n);
    checkOutput("duty_32", 32'(n), 32'd64);

    // Soft stop; a command of 50 issued while in STOP must be ignored
    applyStimulus(1'b0, 1'b1, 8'd50);
    pushRamp(32, 8, 1'b0);
    drainScoreboard();
    checkOutput("stop_busy", 32'(busy), 32'd1);
    pushRamp(8, 0, 1'b0);
    drainScoreboard();
    checkOutput("idle_busy", 32'(busy), 32'd0);

    // Negative command with saturation
    applyStimulus(1'b1, 1'b1, 8'h80);
    checkOutput("sat_set", 32'(sat_flag), 32'd1);
    pushRamp(0, -127, 1'b0);
    sb.push_back('{applied: 8'h81, dir: 1'b1});
    drainScoreboard();
    countPwm(n);
    checkOutput("duty_neg127", 32'(n), 32'd254);

    // Back to zero; the direction is held while inside the deadband
    applyStimulus(1'b1, 1'b1, 8'd0);
    pushRamp(-127, 0, 1'b1);
    drainScoreboard();
    checkOutput("sat_sticky", 32'(sat_flag), 32'd1);

    // Deadband: +2 keeps the output off and leaves the direction unchanged
    applyStimulus(1'b1, 1'b1, 8'd2);
    sb.push_back('{applied: 8'd2, dir: 1'b1});
    drainScoreboard();
    countPwm(n);
    checkOutput("deadband_pwm", 32'(n), 32'd0);

    // Mid-period reset while pwm_out is high
    applyStimulus(1'b1, 1'b1, 8'd64);
    pushRamp(2, 64, 1'b1);
    drainScoreboard();
    repeat (100) @(posedge clk);
    #1;
    checkOutput("pre_rst_pwm", 32'(pwm_out), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_pwm", 32'(pwm_out), 32'd0);
    checkOutput("midrst_sat", 32'(sat_flag), 32'd0);
    checkOutput("midrst_applied", 32'(applied), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      n++;
      #1;
      if (period_start) break;
    end
    checkOutput("restart_cnt", 32'(n), 32'd256);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
